// File: rtl/mpu_irq_arbiter.sv
// mpu_irq_arbiter
// Collects N_SRC asynchronous level interrupt sources, detects rising edges,
// latches them as pending, and arbitrates the masked pending set into one
// registered CPU interrupt with an Avalon-MM register interface.
// Arbitration is fixed priority (lowest index) or round-robin (CTRL.rr).
// Optional build macro: MPU_IRQ_MISS_CNT_EN -- adds the 16-bit saturating
// MISS counter at address 5; without it address 5 reads 0 and ignores writes.
module mpu_irq_arbiter #(
  parameter int N_SRC      = 4,
  parameter bit RR_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] src_in,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(N_SRC - 1);

  // Synchronizer, edge history and post-reset arming
  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;
  logic [N_SRC-1:0] r_hist;
  logic [2:0]       r_arm;

  // Architectural state
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic             r_ctrl_rr;
  logic [0:0]       r_state;
  logic [3:0]       r_grant_idx;
  logic [3:0]       r_rr_ptr;
  logic             r_irq;
  logic [31:0]      r_readdata;

  // Combinational
  logic             w_wr;
  logic             w_wr_pend;
  logic             w_wr_mask;
  logic             w_wr_vec;
  logic             w_wr_ctrl;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_grant_oh;
  logic [N_SRC-1:0] w_pend_clr;
  logic [N_SRC-1:0] w_pend_next;
  logic [N_SRC-1:0] w_elig;
  logic [3:0]       w_win_idx;
  int               w_scan_base;
  int               w_scan_idx;
  logic [0:0]       w_state_next;
  logic [3:0]       w_grant_next;
  logic [3:0]       w_rr_ptr_next;
  logic             w_ack;
  logic             w_revoke;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Only the low bits of writedata carry meaning; fold the rest away.
  assign w_unused = ^writedata;

  assign readdata = r_readdata;
  assign irq      = r_irq;

  // Avalon write decode
  assign w_wr      = chipselect & ~write_n;
  assign w_wr_pend = w_wr & (address == 3'd1);
  assign w_wr_mask = w_wr & (address == 3'd2);
  assign w_wr_vec  = w_wr & (address == 3'd3);
  assign w_wr_ctrl = w_wr & (address == 3'd4);

  // r_arm fills over three edges after reset release, so a source that was
  // already high when reset lifted never looks like a rise: the history flop
  // must have captured a real synchronized level before rises are honoured.
  assign w_rise = r_arm[2] ? (r_sync2 & ~r_hist) : '0;

  // One-hot decode of the current grant, used for ACK clearing and revoke.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_grant_oh
    assign w_grant_oh[gi] = (r_grant_idx == 4'(gi));
  end

  assign w_elig   = r_pend & r_mask;
  assign w_ack    = w_wr_vec & (r_state == ST_GRANT);
  assign w_revoke = ~|(w_elig & w_grant_oh);

  // A new rise wins over any clear (ACK or W1C) landing on the same edge.
  assign w_pend_clr  = (w_wr_pend ? writedata[N_SRC-1:0] : '0) |
                       (w_ack ? w_grant_oh : '0);
  assign w_pend_next = (r_pend & ~w_pend_clr) | w_rise;

  // Winner search: scan from the base index upward (wrapping); iterating the
  // offsets downward lets the smallest offset overwrite and therefore win.
  always_comb begin
    w_win_idx   = 4'd0;
    w_scan_idx  = 0;
    w_scan_base = r_ctrl_rr ? int'(r_rr_ptr) : 0;
    for (int off = N_SRC - 1; off >= 0; off--) begin
      w_scan_idx = w_scan_base + off;
      if (w_scan_idx >= N_SRC) begin
        w_scan_idx = w_scan_idx - N_SRC;
      end
      if (w_elig[w_scan_idx]) begin
        w_win_idx = 4'(w_scan_idx);
      end
    end
  end

  // FSM next state: grant on any eligible source, leave on ACK or revoke.
  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant_idx;
    w_rr_ptr_next = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_next = ST_GRANT;
          w_grant_next = w_win_idx;
        end
      end
      ST_GRANT: begin
        if (w_ack) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = (r_grant_idx == LAST_IDX) ? 4'd0 : r_grant_idx + 4'd1;
        end else if (w_revoke) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef MPU_IRQ_MISS_CNT_EN
  logic             w_wr_miss;
  logic [N_SRC-1:0] w_miss_vec;
  logic [4:0]       w_miss_cnt;
  logic [16:0]      w_miss_sum;
  logic [15:0]      w_miss_next;
  logic [15:0]      r_miss;

  assign w_wr_miss  = w_wr & (address == 3'd5);
  assign w_miss_vec = w_rise & r_pend;

  // Count of sources that rose while already pending this cycle.
  always_comb begin
    w_miss_cnt = 5'd0;
    for (int i = 0; i < N_SRC; i++) begin
      w_miss_cnt = w_miss_cnt + {4'd0, w_miss_vec[i]};
    end
  end

  // Saturating accumulate; a clear loads this cycle's misses so none are lost.
  always_comb begin
    w_miss_sum = {1'b0, r_miss} + {12'd0, w_miss_cnt};
    if (w_wr_miss) begin
      w_miss_next = {11'd0, w_miss_cnt};
    end else if (w_miss_sum[16]) begin
      w_miss_next = 16'hFFFF;
    end else begin
      w_miss_next = w_miss_sum[15:0];
    end
  end

  // MISS counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_miss <= 16'd0;
    end else begin
      r_miss <= w_miss_next;
    end
  end
`endif

  // Read mux over the current register values.
  always_comb begin
    w_rdata = 32'd0;
    case (address)
      3'd0: w_rdata = {{(32 - N_SRC){1'b0}}, r_sync2};
      3'd1: w_rdata = {{(32 - N_SRC){1'b0}}, r_pend};
      3'd2: w_rdata = {{(32 - N_SRC){1'b0}}, r_mask};
      3'd3: w_rdata = {(r_state == ST_GRANT), 27'd0, r_grant_idx};
      3'd4: w_rdata = {31'd0, r_ctrl_rr};
`ifdef MPU_IRQ_MISS_CNT_EN
      3'd5: w_rdata = {16'd0, r_miss};
`endif
      default: w_rdata = 32'd0;
    endcase
  end

  // Input synchronizer, history flop and arming shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
      r_arm   <= 3'd0;
    end else begin
      r_sync1 <= src_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_arm   <= {r_arm[1:0], 1'b1};
    end
  end

  // Pending, mask and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= '0;
      r_mask    <= '0;
      r_ctrl_rr <= RR_DEFAULT;
    end else begin
      r_pend <= w_pend_next;
      if (w_wr_mask) begin
        r_mask <= writedata[N_SRC-1:0];
      end
      if (w_wr_ctrl) begin
        r_ctrl_rr <= writedata[0];
      end
    end
  end

  // FSM state, grant index, round-robin pointer and registered irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= 4'd0;
      r_rr_ptr    <= 4'd0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_grant_idx <= w_grant_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_irq       <= (w_state_next == ST_GRANT);
    end
  end

  // Registered read data, updated every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

endmodule

// File: doc/mpu_irq_arbiter.md
MPU_IRQ_ARBITER -- requirements
Module: mpu_irq_arbiter

Interface
REQ-001 The block SHALL provide parameter N_SRC, default 4, meaning the number of interrupt sources (legal range 1..16).
REQ-002 The block SHALL provide parameter RR_DEFAULT, default 0, meaning the reset value of the CTRL.rr bit (0 = fixed priority, 1 = round-robin).
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port src_in, input, N_SRC bits: asynchronous level inputs such as MPU data-ready and FIFO-watermark lines.
REQ-006 The block SHALL have port address, input, 3 bits: the Avalon-MM word address.
REQ-007 The block SHALL have ports chipselect and write_n, inputs, 1 bit each: Avalon-MM strobes, where a write occurs when chipselect is high and write_n is low.
REQ-008 The block SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-009 The block SHALL have port readdata, output, 32 bits: registered Avalon-MM read data.
REQ-010 The block SHALL have port irq, output, 1 bit: the single interrupt request to the CPU.

Function
REQ-011 Each src_in bit SHALL pass through a 2-flop synchronizer plus one history flop, with rise = sync2 & ~hist.
REQ-012 On a rise, pending[i] SHALL set on the next clk edge, so pending is visible 3 edges after src_in rises.
REQ-013 The register map SHALL be:
- 0 RAW: synced levels, read-only.
- 1 PEND: read, write-1-to-clear.
- 2 MASK: read/write.
- 3 VECTOR: read {bit31 = valid, bits3:0 = grant index}; any write is an ACK.
- 4 CTRL: bit0 = rr, read/write.
- 5 MISS: read, any write clears.
- 6,7: read 0.
REQ-014 Unused upper bits SHALL read 0, and writes to unused bits SHALL be ignored.
REQ-015 readdata SHALL update on every clk edge from the address and register values sampled that cycle, with no dependence on chipselect.
REQ-016 Eligible SHALL be defined as pending & mask.
REQ-017 The FSM SHALL have states IDLE and GRANT.
- IDLE -> GRANT on the edge after eligible != 0; the winner index is latched into grant_idx.
- GRANT -> IDLE on an ACK: pending[grant_idx] is cleared on the same edge.
- GRANT -> IDLE on revoke, when eligible[grant_idx] = 0 because of a PEND W1C or a MASK write. There is no ACK action, and irq falls on the next edge.
REQ-018 irq SHALL be registered and SHALL be high exactly while the FSM is in GRANT, so irq rises 4 edges after src_in rises.
REQ-019 VECTOR.valid SHALL equal (state == GRANT), and grant_idx SHALL hold stable throughout GRANT.
REQ-020 When CTRL.rr = 0, the lowest eligible index SHALL win.
REQ-021 When CTRL.rr = 1, the search SHALL start at rr_ptr, and rr_ptr SHALL become grant_idx+1 mod N_SRC on each ACK only.
REQ-022 An ACK in IDLE SHALL have no effect.
REQ-023 If a new rise on source i coincides with a clear of pending[i] (ACK or W1C), the set SHALL win and pending[i] SHALL remain 1.
REQ-024 A rise on source i while pending[i] = 1 SHALL be counted as a miss.
REQ-025 Simultaneous misses on k sources SHALL add k to MISS, and MISS SHALL saturate at 0xFFFF.
REQ-026 A MISS clear coinciding with misses SHALL load the count of that cycle's misses.
REQ-027 Writing CTRL.rr SHALL take effect at the next IDLE arbitration, and SHALL NOT alter a grant in progress.

Reset
REQ-028 While reset_n is low, the block SHALL hold:
- all synchronizer and history flops, PEND, MASK, MISS, rr_ptr, grant_idx: 0
- state: IDLE
- irq: 0
- readdata: 0
- CTRL.rr: RR_DEFAULT
REQ-029 Reset assertion mid-GRANT SHALL drop irq asynchronously.
REQ-030 Edges seen on src_in during reset SHALL be lost.
REQ-031 A src_in held high through reset release SHALL NOT register a rise.

Configuration
REQ-032 When macro MPU_IRQ_MISS_CNT_EN is defined, the block SHALL implement the 16-bit saturating MISS counter as specified.
REQ-033 When MPU_IRQ_MISS_CNT_EN is undefined, the block SHALL contain no miss logic, address 5 SHALL read 0, and writes to address 5 SHALL be ignored.

Verification
REQ-034 Fixed-priority scenario: MASK=0xF, CTRL=0, src_in[0] rises -> irq high after 4th edge; VECTOR reads 0x8000_0000; ACK -> irq low next edge, PEND=0.
REQ-035 Simultaneous-rise scenario: MASK=0xF, src_in[2] and src_in[1] rise together, rr=0 -> VECTOR=0x8000_0001; after ACK, VECTOR=0x8000_0002; after second ACK, valid=0.
REQ-036 Round-robin scenario: rr=1, all 4 sources pending repeatedly -> grants in order 0,1,2,3,0; PEND bit re-asserted each time.
REQ-037 Revoke scenario: in GRANT idx 3, write MASK=0x7 -> irq low next edge, PEND[3] remains 1, VECTOR.valid=0.
REQ-038 Collision scenario: rise on src 1 in the same cycle as the ACK of grant 1 -> PEND[1]=1 after the edge and irq re-asserts one edge after returning to IDLE.
REQ-039 Miss scenario (MPU_IRQ_MISS_CNT_EN defined): 3 rises on src 0 without ACK -> MISS=2. Without the macro, address 5 reads 0.
